// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS types: opcodes, ALU ops, instruction loader states
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDIU = 6'h09,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL
  } alu_op_t;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    RUN,
    ERROR
  } ld_state_t;

  // sll $0,$0,0
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_imem_ram.sv
// rtl/mips_imem_ram.sv - word RAM, one synchronous write port, one asynchronous read port
module mips_imem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_imem_loader.sv
// rtl/mips_imem_loader.sv - loads a checksummed byte-serial program image into instruction RAM
// and holds the core in reset until the image is verified.
module mips_imem_loader
  import mips_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_in,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

  ld_state_t   r_state, w_state_nxt;
  logic [1:0]  r_bidx;
  logic [15:0] r_widx;
  logic [15:0] r_count;
  logic [7:0]  r_csum;
  logic [23:0] r_word;

  logic        w_accept;
  logic        w_we;
  logic [15:0] w_hdr_count;
  logic [31:0] w_off;
  logic [31:0] w_idx;
  logic [31:0] w_rdata;
  logic        w_hit;

  assign w_hdr_count = {ld_data, r_count[7:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= HDR_LO;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ld_ready    = 1'b0;
    load_done   = 1'b0;
    load_error  = 1'b0;
    case (r_state)
      HDR_LO: begin
        ld_ready = 1'b1;
        if (ld_valid) w_state_nxt = HDR_HI;
      end
      HDR_HI: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if ({16'd0, w_hdr_count} > DEPTH32) w_state_nxt = ERROR;
          else if (w_hdr_count == 16'd0)      w_state_nxt = CSUM;
          else                                w_state_nxt = DATA;
        end
      end
      DATA: begin
        ld_ready = 1'b1;
        if (ld_valid && r_bidx == 2'd3 && r_widx == r_count - 16'd1) w_state_nxt = CSUM;
      end
      CSUM: begin
        ld_ready = 1'b1;
        if (ld_valid) w_state_nxt = (ld_data == r_csum) ? RUN : ERROR;
      end
      RUN:     load_done   = 1'b1;
      ERROR:   load_error  = 1'b1;
      default: w_state_nxt = HDR_LO;
    endcase
  end

  assign w_accept = ld_valid & ld_ready;
  assign w_we     = w_accept & (r_state == DATA) & (r_bidx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bidx  <= 2'd0;
      r_widx  <= 16'd0;
      r_count <= 16'd0;
      r_csum  <= 8'd0;
      r_word  <= 24'd0;
    end else if (w_accept) begin
      case (r_state)
        HDR_LO: r_count[7:0]  <= ld_data;
        HDR_HI: r_count[15:8] <= ld_data;
        DATA: begin
          r_bidx <= r_bidx + 2'd1;
          r_csum <= r_csum ^ ld_data;
          case (r_bidx)
            2'd0:    r_word[7:0]   <= ld_data;
            2'd1:    r_word[15:8]  <= ld_data;
            2'd2:    r_word[23:16] <= ld_data;
            default: r_widx        <= r_widx + 16'd1;
          endcase
        end
        default: ;
      endcase
    end
  end

  mips_imem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_widx[AW-1:0]),
    .i_wdata ({ld_data, r_word}),
    .i_raddr (w_idx[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Addresses below BASE_ADDR wrap to a huge index and fall out of range.
  assign w_off = instr_addr - BASE_ADDR;
  assign w_idx = {2'b00, w_off[31:2]};
  assign w_hit = (r_state == RUN) && (w_off[1:0] == 2'b00) &&
                 (instr_addr >= BASE_ADDR) && (w_idx < DEPTH32);

  assign instr_in   = w_hit ? w_rdata : MIPS_NOP;
  assign core_reset = reset | (r_state != RUN);

endmodule
